// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC controller: FSM state encoding and parameter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adc_pkg;

  localparam int DEF_W_DATA = 18;
  localparam int DEF_N_CH   = 8;
  localparam int DEF_W_OS   = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVST  = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_READ    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Latency: 2 clocks from input change to output (2-3 counting the sampling phase).
// Backpressure: none; a level is passed through unconditionally.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_in,
  input  logic         reset_n_in,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // First flop may go metastable; second gives it a full clock to settle.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/adc_serial_controller.sv
// Sequences CONVST, BUSY wait and an MSB-first serial read of all channels of a simultaneous-sampling ADC.
// Latency: CONVST_LEN + BUSY time + N_CH*W_DATA*2*SCLK_HALF + 1 clocks per conversion; word strobe 1 clock after its last bit.
// Backpressure: none; words are one-cycle strobes that downstream must take, early cstart_in requests are dropped.
module adc_serial_controller
  import adc_pkg::*;
#(
  parameter int W_DATA       = DEF_W_DATA,
  parameter int N_CH         = DEF_N_CH,
  parameter int W_CHAN       = 3,
  parameter int W_OS         = DEF_W_OS,
  parameter int SCLK_HALF    = 2,
  parameter int CONVST_LEN   = 4,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic              cstart_in,
  input  logic [W_OS-1:0]   os_in,
  input  logic              update_in,
  input  logic              busy_in,
  input  logic              sdata_in,
  output logic [W_OS-1:0]   adc_os_out,
  output logic              adc_convst_n_out,
  output logic              adc_cs_n_out,
  output logic              adc_sclk_out,
  output logic [W_DATA-1:0] data_out,
  output logic [W_CHAN-1:0] chan_out,
  output logic              data_valid_out,
  output logic              cycle_done_out,
  output logic              timeout_out
);

  localparam int N_BITS  = N_CH * W_DATA;
  localparam int W_BIT   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int W_WB    = (W_DATA > 1) ? $clog2(W_DATA) : 1;
  localparam int W_DIV   = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int TMR_MAX = (BUSY_TIMEOUT > CONVST_LEN) ? BUSY_TIMEOUT : CONVST_LEN;
  localparam int W_TMR   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  logic busy_s;

  sync_2ff #(.W(1)) u_busy_sync (
    .clk_in    (clk_in),
    .reset_n_in(reset_n_in),
    .d_in      (busy_in),
    .q_out     (busy_s)
  );

  state_e              state_q;
  logic [W_TMR-1:0]    tmr_q;       // CONVST width and BUSY timeout, never live at the same time
  logic [W_DIV-1:0]    div_q;       // clocks within the current SCLK half-period
  logic [W_BIT-1:0]    bit_q;       // bits captured this conversion
  logic [W_WB-1:0]     wb_q;        // bit position within the current word
  logic [W_CHAN-1:0]   ch_q;        // channel currently being shifted in
  logic [W_DATA-1:0]   shift_q;
  logic                pend_q;
  logic [W_OS-1:0]     pend_os_q;
  logic [W_OS-1:0]     adc_os_q;
  logic                convst_n_q;
  logic                cs_n_q;
  logic                sclk_q;
  logic [W_DATA-1:0]   data_q;
  logic [W_CHAN-1:0]   chan_q;
  logic                data_valid_q;
  logic                cycle_done_q;
  logic                timeout_q;
  logic [W_DATA-1:0]   shift_nxt;

  assign shift_nxt = {shift_q[W_DATA-2:0], sdata_in};

  // Conversion sequencer; every output is a register so the ADC pins are glitch-free.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      wb_q         <= '0;
      ch_q         <= '0;
      shift_q      <= '0;
      pend_q       <= 1'b0;
      pend_os_q    <= '0;
      adc_os_q     <= '0;
      convst_n_q   <= 1'b1;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b1;
      data_q       <= '0;
      chan_q       <= '0;
      data_valid_q <= 1'b0;
      cycle_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      cycle_done_q <= 1'b0;

      // OS pins must not move mid-conversion; park the request until idle.
      if (update_in && (state_q != ST_IDLE)) begin
        pend_q    <= 1'b1;
        pend_os_q <= os_in;
      end

      case (state_q)
        ST_IDLE: begin
          if (update_in) begin
            adc_os_q <= os_in;
            pend_q   <= 1'b0;
          end else if (pend_q) begin
            adc_os_q <= pend_os_q;
            pend_q   <= 1'b0;
          end
          if (cstart_in) begin
            state_q    <= ST_CONVST;
            convst_n_q <= 1'b0;
            tmr_q      <= '0;
            timeout_q  <= 1'b0;
          end
        end

        ST_CONVST: begin
          if (tmr_q == W_TMR'(CONVST_LEN - 1)) begin
            convst_n_q <= 1'b1;
            tmr_q      <= '0;
            state_q    <= ST_WAIT_HI;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        ST_WAIT_HI: begin
          if (busy_s) begin
            state_q <= ST_WAIT_LO;
          end else if (tmr_q == W_TMR'(BUSY_TIMEOUT - 1)) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        ST_WAIT_LO: begin
          if (!busy_s) begin
            state_q <= ST_READ;
            cs_n_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            wb_q    <= '0;
            ch_q    <= '0;
          end
        end

        ST_READ: begin
          if (div_q == W_DIV'(SCLK_HALF - 1)) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            // Rising SCLK closes the low half: the ADC's bit has been stable for SCLK_HALF clocks.
            if (!sclk_q) begin
              shift_q <= shift_nxt;
              bit_q   <= bit_q + 1'b1;
              if (wb_q == W_WB'(W_DATA - 1)) begin
                data_q       <= shift_nxt;
                chan_q       <= ch_q;
                data_valid_q <= 1'b1;
                wb_q         <= '0;
                ch_q         <= ch_q + 1'b1;
              end else begin
                wb_q <= wb_q + 1'b1;
              end
              if (bit_q == W_BIT'(N_BITS - 1)) begin
                state_q <= ST_DONE;
                cs_n_q  <= 1'b1;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        ST_DONE: begin
          cycle_done_q <= 1'b1;
          state_q      <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign adc_os_out       = adc_os_q;
  assign adc_convst_n_out = convst_n_q;
  assign adc_cs_n_out     = cs_n_q;
  assign adc_sclk_out     = sclk_q;
  assign data_out         = data_q;
  assign chan_out         = chan_q;
  assign data_valid_out   = data_valid_q;
  assign cycle_done_out   = cycle_done_q;
  assign timeout_out      = timeout_q;

endmodule

// File: tb/tb_adc_serial_controller.sv
// Bench for adc_serial_controller: behavioural ADC (bit queue + BUSY pulse) and per-feature scenario tasks.
// Two instances: default parameters, and a short SCLK_HALF=1 / N_CH=2 variant.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_adc_serial_controller;

  localparam int W_DATA       = 18;
  localparam int N_CH         = 8;
  localparam int W_CHAN       = 3;
  localparam int W_OS         = 3;
  localparam int SCLK_HALF    = 2;
  localparam int CONVST_LEN   = 4;
  localparam int BUSY_TIMEOUT = 1024;
  localparam int S_N_CH       = 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic              reset_n_in;
  logic              cstart_in;
  logic [W_OS-1:0]   os_in;
  logic              update_in;
  logic              busy_in;
  logic              sdata_in;
  logic [W_OS-1:0]   adc_os_out;
  logic              adc_convst_n_out;
  logic              adc_cs_n_out;
  logic              adc_sclk_out;
  logic [W_DATA-1:0] data_out;
  logic [W_CHAN-1:0] chan_out;
  logic              data_valid_out;
  logic              cycle_done_out;
  logic              timeout_out;

  logic              s_cstart_in;
  logic              s_update_in;
  logic              s_sdata_in;
  logic [W_OS-1:0]   s_adc_os_out;
  logic              s_convst_n;
  logic              s_cs_n;
  logic              s_sclk;
  logic [W_DATA-1:0] s_data_out;
  logic [0:0]        s_chan_out;
  logic              s_valid;
  logic              s_done;
  logic              s_timeout;

  adc_serial_controller dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .cstart_in(cstart_in), .os_in(os_in),
    .update_in(update_in), .busy_in(busy_in), .sdata_in(sdata_in),
    .adc_os_out(adc_os_out), .adc_convst_n_out(adc_convst_n_out), .adc_cs_n_out(adc_cs_n_out),
    .adc_sclk_out(adc_sclk_out), .data_out(data_out), .chan_out(chan_out),
    .data_valid_out(data_valid_out), .cycle_done_out(cycle_done_out), .timeout_out(timeout_out)
  );

  adc_serial_controller #(.N_CH(S_N_CH), .W_CHAN(1), .SCLK_HALF(1)) dut_s (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .cstart_in(s_cstart_in), .os_in(os_in),
    .update_in(s_update_in), .busy_in(busy_in), .sdata_in(s_sdata_in),
    .adc_os_out(s_adc_os_out), .adc_convst_n_out(s_convst_n), .adc_cs_n_out(s_cs_n),
    .adc_sclk_out(s_sclk), .data_out(s_data_out), .chan_out(s_chan_out),
    .data_valid_out(s_valid), .cycle_done_out(s_done), .timeout_out(s_timeout)
  );

  int checks = 0;
  int passes = 0;

  // ADC model: conversion result is a flat MSB-first bit stream, one bit per SCLK fall.
  bit adc_bits[$];
  bit s_bits[$];
  logic [W_DATA-1:0] exp_w[$];
  logic [W_DATA-1:0] s_exp_w[$];

  always @(negedge adc_sclk_out) begin
    if (adc_cs_n_out === 1'b0) begin
      if (adc_bits.size() > 0) sdata_in <= adc_bits.pop_front();
      else sdata_in <= 1'b0;
    end
  end

  always @(negedge s_sclk) begin
    if (s_cs_n === 1'b0) begin
      if (s_bits.size() > 0) s_sdata_in <= s_bits.pop_front();
      else s_sdata_in <= 1'b0;
    end
  end

  // BUSY model: rises a little after CONVST ends, stays high busy_len clocks.
  bit busy_en = 1'b0;
  int busy_len = 8;
  always @(negedge adc_convst_n_out or negedge s_convst_n) begin
    if (busy_en) begin
      repeat (CONVST_LEN + $urandom_range(1, 8)) @(negedge clk_in);
      busy_in = 1'b1;
      repeat (busy_len) @(negedge clk_in);
      busy_in = 1'b0;
    end
  end

  // Observation record filled once per sampled cycle.
  int cyc = 0;
  logic [W_DATA-1:0] got_d[$];
  int got_c[$];
  int done_cnt = 0, done_cyc = 0, last_vld_cyc = 0;
  int cs_cur = 0, cs_run = 0, cv_cur = 0, cv_run = 0;
  logic [W_DATA-1:0] s_got_d[$];
  int s_got_c[$];
  int s_done_cnt = 0, s_cs_cur = 0, s_cs_run = 0;
  int s_last_fall = -1, s_gap_min = 1000, s_gap_max = 0;
  logic s_prev_sclk = 1'b1;

  task automatic tick();
    @(negedge clk_in);
    cyc++;
    if (data_valid_out === 1'b1) begin
      got_d.push_back(data_out);
      got_c.push_back(int'(chan_out));
      last_vld_cyc = cyc;
    end
    if (cycle_done_out === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (adc_cs_n_out === 1'b0) cs_cur++;
    else if (cs_cur > 0) begin cs_run = cs_cur; cs_cur = 0; end
    if (adc_convst_n_out === 1'b0) cv_cur++;
    else if (cv_cur > 0) begin cv_run = cv_cur; cv_cur = 0; end
    if (s_valid === 1'b1) begin s_got_d.push_back(s_data_out); s_got_c.push_back(int'(s_chan_out)); end
    if (s_done === 1'b1) s_done_cnt++;
    if (s_cs_n === 1'b0) s_cs_cur++;
    else if (s_cs_cur > 0) begin s_cs_run = s_cs_cur; s_cs_cur = 0; end
    if (s_prev_sclk === 1'b1 && s_sclk === 1'b0) begin
      if (s_last_fall >= 0) begin
        if (cyc - s_last_fall < s_gap_min) s_gap_min = cyc - s_last_fall;
        if (cyc - s_last_fall > s_gap_max) s_gap_max = cyc - s_last_fall;
      end
      s_last_fall = cyc;
    end
    s_prev_sclk = s_sclk;
  endtask

  task automatic load_adc();
    adc_bits.delete();
    foreach (exp_w[c]) for (int b = W_DATA - 1; b >= 0; b--) adc_bits.push_back(exp_w[c][b]);
  endtask

  task automatic random_words();
    exp_w.delete();
    for (int c = 0; c < N_CH; c++) exp_w.push_back(W_DATA'($urandom));
  endtask

  task automatic start_conv();
    cstart_in = 1'b1;
    tick();
    cstart_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt > d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n_in = 1'b0; cstart_in = 1'b0; update_in = 1'b0; os_in = '0; busy_in = 1'b0;
    sdata_in = 1'b0; s_cstart_in = 1'b0; s_update_in = 1'b0; s_sdata_in = 1'b0;
    repeat (3) tick();
    checks++; if (adc_os_out !== 3'd0) $display("FAIL reset_os got=%0h exp=0", adc_os_out); else passes++;
    checks++; if (adc_convst_n_out !== 1'b1) $display("FAIL reset_convst got=%b exp=1", adc_convst_n_out); else passes++;
    checks++; if (adc_cs_n_out !== 1'b1) $display("FAIL reset_cs got=%b exp=1", adc_cs_n_out); else passes++;
    checks++; if (adc_sclk_out !== 1'b1) $display("FAIL reset_sclk got=%b exp=1", adc_sclk_out); else passes++;
    checks++; if (data_out !== '0) $display("FAIL reset_data got=%0h exp=0", data_out); else passes++;
    checks++; if (chan_out !== '0) $display("FAIL reset_chan got=%0d exp=0", chan_out); else passes++;
    checks++; if (data_valid_out !== 1'b0) $display("FAIL reset_valid got=%b exp=0", data_valid_out); else passes++;
    checks++; if (cycle_done_out !== 1'b0) $display("FAIL reset_done got=%b exp=0", cycle_done_out); else passes++;
    checks++; if (timeout_out !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", timeout_out); else passes++;
    reset_n_in = 1'b1;
    busy_en = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_corner_words();
    int base;
    bit ok;
    random_words();
    exp_w[0] = 18'h1FFFF; exp_w[1] = 18'h20000; exp_w[7] = 18'h00001;
    load_adc();
    base = got_d.size();
    start_conv();
    wait_done(3000, ok);
    tick();
    checks++; if (!ok) $display("FAIL corner_done_seen got=0 exp=1"); else passes++;
    checks++; if (got_d.size() - base != N_CH) $display("FAIL corner_count got=%0d exp=%0d", got_d.size() - base, N_CH); else passes++;
    if (got_d.size() - base == N_CH) begin
      for (int c = 0; c < N_CH; c++) begin
        checks++; if (got_d[base + c] !== exp_w[c]) $display("FAIL corner_data ch%0d got=%05h exp=%05h", c, got_d[base + c], exp_w[c]); else passes++;
        checks++; if (got_c[base + c] != c) $display("FAIL corner_chan got=%0d exp=%0d", got_c[base + c], c); else passes++;
      end
    end
    checks++; if (done_cyc != last_vld_cyc + 1) $display("FAIL corner_done_timing got=%0d exp=%0d", done_cyc - last_vld_cyc, 1); else passes++;
    checks++; if (cs_run != N_CH * W_DATA * 2 * SCLK_HALF) $display("FAIL corner_read_len got=%0d exp=%0d", cs_run, N_CH * W_DATA * 2 * SCLK_HALF); else passes++;
    checks++; if (cv_run != CONVST_LEN) $display("FAIL corner_convst_len got=%0d exp=%0d", cv_run, CONVST_LEN); else passes++;
  endtask

  task automatic test_random_convs();
    int base, mism;
    bit ok;
    logic [W_OS-1:0] os_v;
    for (int k = 0; k < 3; k++) begin
      os_v = W_OS'($urandom);
      os_in = os_v; update_in = 1'b1;
      tick();
      update_in = 1'b0;
      checks++; if (adc_os_out !== os_v) $display("FAIL rand_os_idle got=%0d exp=%0d", adc_os_out, os_v); else passes++;
      random_words();
      load_adc();
      base = got_d.size();
      busy_len = $urandom_range(2, 30);
      start_conv();
      wait_done(3000, ok);
      checks++; if (!ok || got_d.size() - base != N_CH) $display("FAIL rand_count got=%0d exp=%0d", got_d.size() - base, N_CH); else passes++;
      mism = 0;
      if (got_d.size() - base == N_CH)
        for (int c = 0; c < N_CH; c++) if (got_d[base + c] !== exp_w[c] || got_c[base + c] != c) mism++;
      checks++; if (mism != 0) $display("FAIL rand_words got=%0d_bad exp=0_bad", mism); else passes++;
      repeat ($urandom_range(1, 5)) tick();
    end
    busy_len = 8;
  endtask

  task automatic test_timeout();
    int n, base, d0;
    bit ok;
    busy_en = 1'b0;
    adc_bits.delete();
    base = got_d.size();
    d0 = done_cnt;
    start_conv();
    n = 0;
    while (timeout_out !== 1'b1 && n < 1200) begin tick(); n++; end
    checks++; if (n != CONVST_LEN + BUSY_TIMEOUT) $display("FAIL timeout_delay got=%0d exp=%0d", n, CONVST_LEN + BUSY_TIMEOUT); else passes++;
    repeat (20) tick();
    checks++; if (timeout_out !== 1'b1) $display("FAIL timeout_sticky got=%b exp=1", timeout_out); else passes++;
    checks++; if (got_d.size() != base || done_cnt != d0) $display("FAIL timeout_no_data got=%0d exp=0", got_d.size() - base + done_cnt - d0); else passes++;
    busy_en = 1'b1;
    random_words();
    load_adc();
    start_conv();
    checks++; if (timeout_out !== 1'b0) $display("FAIL timeout_clear got=%b exp=0", timeout_out); else passes++;
    wait_done(3000, ok);
    checks++; if (!ok || got_d.size() - base != N_CH) $display("FAIL timeout_recover got=%0d exp=%0d", got_d.size() - base, N_CH); else passes++;
  endtask

  task automatic test_os_update();
    int n;
    bit moved, ok;
    os_in = 3'd5; update_in = 1'b1;
    tick();
    update_in = 1'b0;
    checks++; if (adc_os_out !== 3'd5) $display("FAIL os_idle got=%0d exp=5", adc_os_out); else passes++;
    random_words();
    load_adc();
    start_conv();
    n = 0;
    while (adc_cs_n_out !== 1'b0 && n < 200) begin tick(); n++; end
    repeat (10) tick();
    os_in = 3'd3; update_in = 1'b1;
    tick();
    update_in = 1'b0; os_in = 3'd0;
    moved = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (adc_os_out !== 3'd5) moved = 1'b1;
      if (cycle_done_out === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (moved || !ok) $display("FAIL os_held_in_read got=%0d exp=5", adc_os_out); else passes++;
    tick();
    checks++; if (adc_os_out !== 3'd3) $display("FAIL os_pending_applied got=%0d exp=3", adc_os_out); else passes++;
    random_words();
    load_adc();
    os_in = 3'd6; update_in = 1'b1; cstart_in = 1'b1;
    tick();
    update_in = 1'b0; cstart_in = 1'b0;
    checks++; if (adc_os_out !== 3'd6) $display("FAIL os_with_cstart got=%0d exp=6", adc_os_out); else passes++;
    checks++; if (adc_convst_n_out !== 1'b0) $display("FAIL convst_with_update got=%b exp=0", adc_convst_n_out); else passes++;
    wait_done(3000, ok);
  endtask

  task automatic test_cstart_ignored();
    int n, d0, base;
    bit ok;
    busy_len = 40;
    random_words();
    load_adc();
    d0 = done_cnt;
    base = got_d.size();
    start_conv();
    n = 0;
    while (busy_in !== 1'b1 && n < 60) begin tick(); n++; end
    repeat (6) tick();
    cstart_in = 1'b1;
    tick();
    cstart_in = 1'b0;
    wait_done(3000, ok);
    repeat (1000) tick();
    checks++; if (done_cnt - d0 != 1) $display("FAIL ignored_done_count got=%0d exp=1", done_cnt - d0); else passes++;
    checks++; if (got_d.size() - base != N_CH) $display("FAIL ignored_word_count got=%0d exp=%0d", got_d.size() - base, N_CH); else passes++;
    busy_len = 8;
  endtask

  task automatic test_reset_mid_read();
    int n, bits, base, d0;
    logic prev;
    random_words();
    load_adc();
    start_conv();
    n = 0;
    while (adc_cs_n_out !== 1'b0 && n < 200) begin tick(); n++; end
    bits = 0;
    prev = adc_sclk_out;
    n = 0;
    while (bits < 40 && n < 400) begin
      tick(); n++;
      if (prev === 1'b0 && adc_sclk_out === 1'b1) bits++;
      prev = adc_sclk_out;
    end
    checks++; if (bits != 40) $display("FAIL midread_reach_bit40 got=%0d exp=40", bits); else passes++;
    #2 reset_n_in = 1'b0;
    #1;
    checks++; if (adc_cs_n_out !== 1'b1) $display("FAIL midread_cs got=%b exp=1", adc_cs_n_out); else passes++;
    checks++; if (adc_sclk_out !== 1'b1) $display("FAIL midread_sclk got=%b exp=1", adc_sclk_out); else passes++;
    checks++; if (data_valid_out !== 1'b0 || data_out !== '0) $display("FAIL midread_data got=%0h exp=0", data_out); else passes++;
    tick(); tick();
    reset_n_in = 1'b1;
    adc_bits.delete();
    base = got_d.size();
    d0 = done_cnt;
    repeat (800) tick();
    checks++; if (got_d.size() != base || done_cnt != d0) $display("FAIL midread_no_strobes got=%0d exp=0", got_d.size() - base + done_cnt - d0); else passes++;
  endtask

  task automatic test_small_variant();
    int d0, base;
    bit ok;
    s_exp_w.delete();
    s_bits.delete();
    for (int c = 0; c < S_N_CH; c++) s_exp_w.push_back(W_DATA'($urandom));
    foreach (s_exp_w[c]) for (int b = W_DATA - 1; b >= 0; b--) s_bits.push_back(s_exp_w[c][b]);
    s_last_fall = -1; s_gap_min = 1000; s_gap_max = 0;
    d0 = s_done_cnt;
    base = s_got_d.size();
    s_cstart_in = 1'b1;
    tick();
    s_cstart_in = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (s_done_cnt > d0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) $display("FAIL small_done_seen got=0 exp=1"); else passes++;
    checks++; if (s_cs_run != 72) $display("FAIL small_read_len got=%0d exp=72", s_cs_run); else passes++;
    checks++; if (s_gap_min != 2 || s_gap_max != 2) $display("FAIL small_sclk_period got=%0d..%0d exp=2", s_gap_min, s_gap_max); else passes++;
    checks++; if (s_got_d.size() - base != S_N_CH) $display("FAIL small_count got=%0d exp=%0d", s_got_d.size() - base, S_N_CH); else passes++;
    if (s_got_d.size() - base == S_N_CH) begin
      for (int c = 0; c < S_N_CH; c++) begin
        checks++; if (s_got_d[base + c] !== s_exp_w[c]) $display("FAIL small_data ch%0d got=%05h exp=%05h", c, s_got_d[base + c], s_exp_w[c]); else passes++;
        checks++; if (s_got_c[base + c] != c) $display("FAIL small_chan got=%0d exp=%0d", s_got_c[base + c], c); else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_corner_words();
    test_random_convs();
    test_timeout();
    test_os_update();
    test_cstart_ignored();
    test_reset_mid_read();
    test_small_variant();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish (%0d/%0d so far)", passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
